// File: rtl/mem_stage.sv
// Memory-access pipeline stage: captures the execute result, extracts and extends
// load data from the synchronous SRAM, and forwards the result to write-back.
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    output logic        ms_allowin,
    input  logic        es_to_ms_valid,
    input  logic [38:0] es_rf_collect,
    input  logic [31:0] es_pc,
    input  logic [4:0]  es_mem_inst_bus,
    input  logic [31:0] data_sram_rdata,
    input  logic        ws_allowin,
    output logic        ms_to_ws_valid,
    output logic [69:0] ms_to_ws_bus,
    output logic [38:0] ms_rf_collect
);

    logic        ms_valid_q,  ms_valid_d;
    logic [38:0] collect_q,   collect_d;
    logic [31:0] pc_q,        pc_d;
    logic [4:0]  inst_q,      inst_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_data_q,  buf_data_d;

    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic        accept;
    logic        leave;
    logic [31:0] mem_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign res_from_mem = collect_q[38];
    assign rf_we        = collect_q[37];
    assign rf_waddr     = collect_q[36:32];
    assign ex_result    = collect_q[31:0];

    assign ms_allowin = ~ms_valid_q | ws_allowin;
    assign accept     = es_to_ms_valid & ms_allowin;
    assign leave      = ms_valid_q & ws_allowin;

    always_comb begin
        ms_valid_d  = ms_valid_q;
        collect_d   = collect_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;

        if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end
        if (accept) begin
            collect_d = es_rf_collect;
            pc_d      = es_pc;
            inst_d    = es_mem_inst_bus;
        end
        // SRAM data is only valid for one cycle; hold it while write-back stalls.
        // A departing or newly accepted instruction always releases the buffer.
        if (leave || accept) begin
            buf_valid_d = 1'b0;
        end else if (ms_valid_q && res_from_mem && !buf_valid_q && !ws_allowin) begin
            buf_valid_d = 1'b1;
            buf_data_d  = data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid_q  <= 1'b0;
            collect_q   <= '0;
            pc_q        <= '0;
            inst_q      <= '0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            collect_q   <= collect_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
        end
    end

    assign mem_word = buf_valid_q ? buf_data_q : data_sram_rdata;

    always_comb begin
        byte_sel = mem_word[7:0];
        case (ex_result[1:0])
            2'd0: byte_sel = mem_word[7:0];
            2'd1: byte_sel = mem_word[15:8];
            2'd2: byte_sel = mem_word[23:16];
            2'd3: byte_sel = mem_word[31:24];
            default: byte_sel = mem_word[7:0];
        endcase
        half_sel = ex_result[1] ? mem_word[31:16] : mem_word[15:0];

        if (inst_q[4]) begin
            load_data = mem_word;
        end else if (inst_q[3]) begin
            load_data = {{16{half_sel[15]}}, half_sel};
        end else if (inst_q[1]) begin
            load_data = {16'h0000, half_sel};
        end else if (inst_q[2]) begin
            load_data = {{24{byte_sel[7]}}, byte_sel};
        end else if (inst_q[0]) begin
            load_data = {24'h000000, byte_sel};
        end else begin
            load_data = mem_word;
        end
    end

    assign final_result = res_from_mem ? load_data : ex_result;

    assign ms_to_ws_valid = ms_valid_q;
    assign ms_to_ws_bus   = ms_valid_q ? {rf_we, rf_waddr, final_result, pc_q} : '0;
    assign ms_rf_collect  = {res_from_mem & ms_valid_q, rf_we & ms_valid_q, rf_waddr, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a per-cycle instruction-level model plus
// hand-computed literal expectations for the named scenarios.
module tb_mem_stage;

    logic        clk;
    logic        resetn;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [38:0] es_rf_collect;
    logic [31:0] es_pc;
    logic [4:0]  es_mem_inst_bus;
    logic [31:0] data_sram_rdata;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [38:0] ms_rf_collect;

    int n_chk  = 0;
    int n_fail = 0;

    mem_stage dut (
        .clk            (clk),
        .resetn         (resetn),
        .ms_allowin     (ms_allowin),
        .es_to_ms_valid (es_to_ms_valid),
        .es_rf_collect  (es_rf_collect),
        .es_pc          (es_pc),
        .es_mem_inst_bus(es_mem_inst_bus),
        .data_sram_rdata(data_sram_rdata),
        .ws_allowin     (ws_allowin),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ms_to_ws_bus   (ms_to_ws_bus),
        .ms_rf_collect  (ms_rf_collect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [69:0] got, input logic [69:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Load result from the word, load type and byte offset, by arithmetic.
    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [4:0] t, input logic [1:0] off);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (32'(off) * 8)) & 32'hFF;
        h = (w >> (off[1] ? 16 : 0)) & 32'hFFFF;
        if (t[4] || t == 5'd0) return w;
        if (t[3]) return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
        if (t[1]) return h;
        if (t[2]) return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
        return b;
    endfunction

    // Model: the instruction currently in the stage and the word it loads.
    // The word is whatever the SRAM returns during its first cycle in the stage.
    logic        m_valid = 1'b0, m_rm = 1'b0, m_we = 1'b0, m_known = 1'b0;
    logic [4:0]  m_wa = '0, m_t = '0;
    logic [31:0] m_res = '0, m_pc = '0, m_word = '0;

    initial begin
        logic [31:0] word, fin;
        logic        exp_allow;
        @(posedge clk);
        forever begin
            @(negedge clk);
            word      = (m_valid && m_known) ? m_word : data_sram_rdata;
            fin       = m_rm ? load_val(word, m_t, m_res[1:0]) : m_res;
            exp_allow = !m_valid || ws_allowin;
            check("allowin", 70'(ms_allowin), 70'(exp_allow));
            check("to_ws_valid", 70'(ms_to_ws_valid), 70'(m_valid));
            check("to_ws_bus", ms_to_ws_bus, m_valid ? {m_we, m_wa, fin, m_pc} : 70'd0);
            check("rf_collect", 70'(ms_rf_collect), 70'({m_rm & m_valid, m_we & m_valid, m_wa, fin}));

            if (m_valid && !m_known) begin
                m_known = 1'b1;
                m_word  = data_sram_rdata;
            end
            if (!resetn) begin
                m_valid = 0; m_rm = 0; m_we = 0; m_known = 0;
                m_wa = '0; m_t = '0; m_res = '0; m_pc = '0;
            end else if (exp_allow) begin
                m_known = 1'b0;
                m_valid = es_to_ms_valid;
                if (es_to_ms_valid) begin
                    {m_rm, m_we, m_wa, m_res} = es_rf_collect;
                    m_pc = es_pc;
                    m_t  = es_mem_inst_bus;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic rm, input logic we, input logic [4:0] wa,
                        input logic [31:0] res, input logic [31:0] pc, input logic [4:0] t);
        es_to_ms_valid  = 1'b1;
        es_rf_collect   = {rm, we, wa, res};
        es_pc           = pc;
        es_mem_inst_bus = t;
    endtask

    task automatic do_load(input string nm, input logic [4:0] t, input logic [1:0] off, input logic [31:0] exp);
        send(1'b1, 1'b1, 5'd10, 32'h0000_2000 | 32'(off), 32'h1C00_0100, t);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        check(nm, 70'(ms_to_ws_bus[63:32]), 70'(exp));
        tick();
    endtask

    initial begin
        resetn          = 1'b0;
        es_to_ms_valid  = 1'b0;
        es_rf_collect   = '0;
        es_pc           = '0;
        es_mem_inst_bus = '0;
        data_sram_rdata = '0;
        ws_allowin      = 1'b1;
        tick(); tick();
        check("reset_valid", 70'(ms_to_ws_valid), 70'd0);
        check("reset_allowin", 70'(ms_allowin), 70'd1);
        check("reset_collect", 70'(ms_rf_collect), 70'd0);
        resetn = 1'b1;
        tick();

        // ALU passthrough
        send(1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0000, 5'd0);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        check("alu_valid", 70'(ms_to_ws_valid), 70'd1);
        check("alu_bus", ms_to_ws_bus, {1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0000});
        tick();
        check("alu_drain", 70'(ms_to_ws_valid), 70'd0);

        // Back-to-back ALU ops at full throughput
        for (int unsigned i = 0; i < 4; i++) begin
            send(1'b0, 1'b1, 5'(i + 1), 32'h100 * i, 32'h1C00_0010 + 4 * i, 5'd0);
            tick();
        end
        es_to_ms_valid = 1'b0;
        tick();

        // Load extraction and extension
        data_sram_rdata = 32'h80FF_7F01;
        do_load("ld_b_off3",  5'b00100, 2'd3, 32'hFFFF_FF80);
        do_load("ld_bu_off1", 5'b00001, 2'd1, 32'h0000_007F);
        do_load("ld_h_off2",  5'b01000, 2'd2, 32'hFFFF_80FF);
        do_load("ld_hu_off0", 5'b00010, 2'd0, 32'h0000_7F01);
        do_load("ld_w",       5'b10000, 2'd0, 32'h80FF_7F01);
        do_load("ld_h_off3",  5'b01000, 2'd3, 32'hFFFF_80FF);
        do_load("prio_h_b",   5'b01101, 2'd2, 32'hFFFF_80FF);
        do_load("prio_w_all", 5'b11111, 2'd1, 32'h80FF_7F01);
        do_load("none_set",   5'b00000, 2'd2, 32'h80FF_7F01);

        // Stall hold
        ws_allowin = 1'b0;
        send(1'b1, 1'b1, 5'd3, 32'h0000_0100, 32'h1C00_0200, 5'b10000);
        tick();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'hDEAD_BEEF;
        #1;
        check("stall_c0", 70'(ms_to_ws_bus[63:32]), 70'(32'hDEAD_BEEF));
        check("stall_allow", 70'(ms_allowin), 70'd0);
        tick();
        data_sram_rdata = 32'h1111_1111;
        #1;
        check("stall_c1", 70'(ms_to_ws_bus[63:32]), 70'(32'hDEAD_BEEF));
        tick();
        check("stall_c2", 70'(ms_to_ws_bus[63:32]), 70'(32'hDEAD_BEEF));
        check("stall_allow2", 70'(ms_allowin), 70'd0);
        ws_allowin = 1'b1;
        #1;
        check("stall_leave", 70'(ms_to_ws_bus[63:32]), 70'(32'hDEAD_BEEF));
        tick();
        check("stall_gone", 70'(ms_to_ws_valid), 70'd0);

        // Leave and accept in the same cycle
        ws_allowin = 1'b0;
        send(1'b1, 1'b1, 5'd4, 32'h0000_0200, 32'h1C00_0300, 5'b10000);
        tick();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h5555_5555;
        tick();
        data_sram_rdata = 32'h0000_0000;
        tick();
        ws_allowin = 1'b1;
        send(1'b1, 1'b1, 5'd6, 32'h0000_0300, 32'h1C00_0304, 5'b10000);
        #1;
        check("la_old", 70'(ms_to_ws_bus[63:32]), 70'(32'h5555_5555));
        tick();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'hCAFE_0000;
        #1;
        check("la_new", ms_to_ws_bus, {1'b1, 5'd6, 32'hCAFE_0000, 32'h1C00_0304});
        tick();

        // Reset during a buffered stall
        ws_allowin = 1'b0;
        send(1'b1, 1'b1, 5'd9, 32'h0000_0400, 32'h1C00_0400, 5'b10000);
        tick();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'hAAAA_5555;
        tick();
        resetn = 1'b0;
        tick();
        check("rst_valid", 70'(ms_to_ws_valid), 70'd0);
        check("rst_collect", 70'(ms_rf_collect), 70'd0);
        check("rst_allow", 70'(ms_allowin), 70'd1);
        resetn     = 1'b1;
        ws_allowin = 1'b1;
        send(1'b0, 1'b1, 5'd2, 32'h0000_0042, 32'h1C00_0500, 5'd0);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        check("rst_alu", ms_to_ws_bus, {1'b1, 5'd2, 32'h0000_0042, 32'h1C00_0500});
        tick();

        // Forwarding bundle
        data_sram_rdata = 32'h0BAD_F00D;
        send(1'b1, 1'b1, 5'd7, 32'h0000_0500, 32'h1C00_0600, 5'b10000);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        check("fwd_flags", 70'(ms_rf_collect[38:37]), 70'(2'b11));
        check("fwd_waddr", 70'(ms_rf_collect[36:32]), 70'd7);
        check("fwd_data", 70'(ms_rf_collect[31:0]), 70'(32'h0BAD_F00D));
        tick();
        check("fwd_idle", 70'(ms_rf_collect[38:37]), 70'd0);

        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage. It sits directly downstream of the execute stage and upstream of write-back.
- Accepts the execute-stage result bundle and returns load data from the synchronous data SRAM, whose request was issued during execute.
- Performs byte/half extraction and sign/zero extension, then forwards the final result to write-back.
- Publishes a forwarding/hazard bundle to decode.
- Holds returned SRAM data internally while write-back stalls, because execute may issue a new SRAM request during the stall.

Parameters:
- None. The datapath is fixed at 32 bits; register index is fixed at 5 bits.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- ms_allowin  out  1  stage can accept a new instruction this cycle
- es_to_ms_valid  in  1  execute offers an instruction
- es_rf_collect  in  39  {res_from_mem[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}; ex_result is the load address for loads
- es_pc  in  32  PC of the offered instruction
- es_mem_inst_bus  in  5  load type: [4] ld_w, [3] ld_h, [2] ld_b, [1] ld_hu, [0] ld_bu
- data_sram_rdata  in  32  SRAM read data, valid the cycle after the execute-stage request
- ws_allowin  in  1  write-back can accept
- ms_to_ws_valid  out  1  instruction ready for write-back
- ms_to_ws_bus  out  70  {rf_we[69], rf_waddr[68:64], final_result[63:32], pc[31:0]}
- ms_rf_collect  out  39  {res_from_mem & ms_valid, rf_we & ms_valid, rf_waddr, final_result}; to decode for hazard/forwarding

Behaviour:
- Reset: resetn sampled on the clk edge, active low, synchronous.
  - Clears ms_valid, all captured fields, the rdata buffer and its valid flag.
  - Consequences: ms_to_ws_valid=0, ms_to_ws_bus=0, ms_rf_collect=0, ms_allowin=1.
  - Reset mid-stall discards the held instruction and buffered data.
- Handshake:
  - ms_ready_go=1 always.
  - ms_allowin = ~ms_valid | ws_allowin.
  - ms_to_ws_valid = ms_valid.
  - When ms_allowin is high, ms_valid <= es_to_ms_valid.
  - Payload registers (collect fields, pc, load type) load only when es_to_ms_valid & ms_allowin; otherwise they hold.
- Latency: 1 cycle from acceptance to ms_to_ws_valid. Back-to-back throughput is 1 instruction/cycle when ws_allowin=1.
- rdata buffer (buf_valid, buf_data):
  - Set on an edge where ms_valid & res_from_mem & ~buf_valid & ~ws_allowin: capture data_sram_rdata.
  - Cleared on an edge where ms_valid & ws_allowin (instruction leaves), or a new instruction is accepted.
  - If leave and accept coincide, the buffer is cleared; the new instruction reads live rdata.
  - mem_word = buf_valid ? buf_data : data_sram_rdata.
  - Once buffered, later changes to data_sram_rdata must not affect the result.
- Load extraction (off = ex_result[1:0]):
  - byte = mem_word[off*8 +: 8].
  - half = off[1] ? mem_word[31:16] : mem_word[15:0]; off[0] is ignored, no alignment exception.
  - ld_b / ld_bu: sign / zero extend byte.
  - ld_h / ld_hu: sign / zero extend half.
  - ld_w: mem_word.
  - Priority if more than one bit is set: ld_w > ld_h > ld_hu > ld_b > ld_bu.
  - No bit set with res_from_mem=1: treat as ld_w.
- final_result = res_from_mem ? load_data : ex_result. Combinational; changes only through the buffer rule above.
- ms_to_ws_bus rf_we field is the raw captured rf_we, gated by ms_valid; the bus is 0 when ms_valid=0.
- No store handling: stores complete in execute and pass through with rf_we=0.

Test Plan:
- ALU passthrough: accept {res_from_mem=0, rf_we=1, waddr=5, result=0x1234_5678}, pc=0x1C00_0000, ws_allowin=1.
  - Next cycle: ms_to_ws_valid=1, bus = {1, 5, 0x12345678, 0x1C000000}.
  - Following cycle: valid=0 if no new input.
- Load extension: rdata=0x80FF_7F01.
  - ld_b, off=3 → 0xFFFFFF80.
  - ld_bu, off=1 → 0x7F.
  - ld_h, off=2 → 0xFFFF80FF.
  - ld_hu, off=0 → 0x7F01.
  - ld_w → 0x80FF7F01.
- Stall hold: ld_w accepted with rdata=0xDEADBEEF, ws_allowin=0 for 3 cycles, rdata changes to 0x11111111 after cycle 1.
  - final_result stays 0xDEADBEEF and ms_allowin=0 throughout.
  - On ws_allowin=1 the instruction leaves with 0xDEADBEEF.
- Leave-and-accept same cycle: stalled buffered load leaves while a new ld_w (rdata=0xCAFE0000) is accepted.
  - New result is 0xCAFE0000, not stale buffer data.
- Reset mid-stall: resetn=0 one cycle during a buffered stall.
  - ms_to_ws_valid=0, ms_rf_collect=0, ms_allowin=1.
  - Subsequent ALU op flows normally.
- Forwarding bundle: valid ld_w to r7.
  - ms_rf_collect[38:37]=2'b11 and [36:32]=7.
  - When ms_valid=0, bits [38:37]=0.
